// File: rtl/cex_pkg.sv
// Shared definitions for the cex ladder family: retreat-mode encodings and the
// width-independent next-state rule used by the ladder FSM.
package cex_pkg;

    localparam logic [1:0] RM_HOLD = 2'd0;
    localparam logic [1:0] RM_ZERO = 2'd1;
    localparam logic [1:0] RM_BACK = 2'd2;
    localparam logic [1:0] RM_RSVD = 2'd3;

    // Priority: absorbing top, auto-advance from 0, advance on i, else retreat mode.
    function automatic int next_state(input int state, input logic i,
                                      input logic [1:0] mode, input logic auto0,
                                      input int depth);
        int ns;
        if (state == depth - 1) begin
            ns = state;
        end else if (state == 0 && auto0) begin
            ns = 1;
        end else if (i) begin
            ns = state + 1;
        end else begin
            case (mode)
                RM_ZERO:          ns = 0;
                RM_BACK:          ns = (state == 0) ? 0 : state - 1;
                RM_HOLD, RM_RSVD: ns = state;
                default:          ns = state;
            endcase
        end
        return ns;
    endfunction

endpackage

// File: rtl/cex_sat_counter.sv
// Saturating up-counter with synchronous clear; clr wins over inc.
module cex_sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && count != '1) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cex_ladder.sv
// DEPTH-state ladder FSM with clock enable, one-hot decode, dwell counter and
// registered advance/retreat pulses.
module cex_ladder
    import cex_pkg::*;
#(
    parameter int                   DEPTH        = 4,
    parameter int                   AUTO0        = 1,
    parameter logic [2*DEPTH-1:0]   RETREAT_MODE = 'h04,
    parameter int                   DWELL_W      = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic                       i,
    output logic [$clog2(DEPTH)-1:0]   state,
    output logic [DEPTH-1:0]           at_state,
    output logic                       done,
    output logic [DWELL_W-1:0]         dwell,
    output logic                       advanced,
    output logic                       retreated
);

    localparam int SW  = $clog2(DEPTH);
    // Mode table padded to every encodable index so the lookup never runs off the end.
    localparam int RMW = 2 * (2 ** SW);
    localparam logic [RMW-1:0] RM_EXT = RMW'(RETREAT_MODE);

    if (DEPTH < 2) begin : g_bad_depth
        $error("cex_ladder: DEPTH must be at least 2");
    end
    if (DWELL_W < 1) begin : g_bad_dwell
        $error("cex_ladder: DWELL_W must be at least 1");
    end

    logic [1:0]    mode;
    logic [SW-1:0] state_nx;
    logic          moved;

    assign mode = RM_EXT[{state, 1'b0} +: 2];

    always_comb begin
        state_nx = SW'(next_state(int'(state), i, mode, AUTO0 != 0, DEPTH));
    end

    assign moved = (state_nx != state);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= '0;
            advanced  <= 1'b0;
            retreated <= 1'b0;
        end else if (en) begin
            state     <= state_nx;
            advanced  <= (state_nx > state);
            retreated <= (state_nx < state);
        end else begin
            advanced  <= 1'b0;
            retreated <= 1'b0;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_decode
        assign at_state[k] = (state == SW'(k));
    end

    assign done = (state == SW'(DEPTH - 1));

    cex_sat_counter #(
        .WIDTH (DWELL_W)
    ) u_dwell (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (en && moved),
        .inc     (en && !moved),
        .count   (dwell)
    );

endmodule

// File: tb/tb_cex_ladder.sv
// Scoreboard bench for cex_ladder: a default 4-state instance and a 6-state
// all-back-one instance share one stimulus stream.
module tb_cex_ladder;

    typedef struct {
        int st;
        int dw;
        bit adv;
        bit ret;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       en;
    logic       i;

    logic [1:0] st_a;
    logic [3:0] at_a;
    logic       done_a;
    logic [3:0] dw_a;
    logic       adv_a, ret_a;

    logic [2:0] st_b;
    logic [5:0] at_b;
    logic       done_b;
    logic [3:0] dw_b;
    logic       adv_b, ret_b;

    int n_chk  = 0;
    int n_fail = 0;

    exp_t cur_a, cur_b;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clock = ~clock;

    cex_ladder dut_a (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (en),
        .i         (i),
        .state     (st_a),
        .at_state  (at_a),
        .done      (done_a),
        .dwell     (dw_a),
        .advanced  (adv_a),
        .retreated (ret_a)
    );

    cex_ladder #(
        .DEPTH        (6),
        .AUTO0        (0),
        .RETREAT_MODE (12'hAAA),
        .DWELL_W      (4)
    ) dut_b (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (en),
        .i         (i),
        .state     (st_b),
        .at_state  (at_b),
        .done      (done_b),
        .dwell     (dw_b),
        .advanced  (adv_b),
        .retreated (ret_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference ladder written straight from the behavioural description.
    function automatic exp_t model(input exp_t c, input bit e, input bit iv,
                                   input int depth, input bit auto0, input int rm);
        exp_t n;
        int   nx;
        int   m;
        n = c;
        if (!e) begin
            n.adv = 1'b0;
            n.ret = 1'b0;
            return n;
        end
        m = (rm >> (2 * c.st)) & 3;
        if (c.st == depth - 1)          nx = c.st;
        else if (c.st == 0 && auto0)    nx = 1;
        else if (iv)                    nx = c.st + 1;
        else if (m == 1)                nx = 0;
        else if (m == 2)                nx = (c.st == 0) ? 0 : c.st - 1;
        else                            nx = c.st;
        n.adv = (nx > c.st);
        n.ret = (nx < c.st);
        n.dw  = (nx != c.st) ? 0 : ((c.dw < 15) ? c.dw + 1 : 15);
        n.st  = nx;
        return n;
    endfunction

    task automatic step(input bit e, input bit iv);
        exp_t ea, eb;
        en = e;
        i  = iv;
        cur_a = model(cur_a, e, iv, 4, 1'b1, 32'h04);
        cur_b = model(cur_b, e, iv, 6, 1'b0, 32'hAAA);
        q_a.push_back(cur_a);
        q_b.push_back(cur_b);
        @(posedge clock);
        #1;
        if (q_a.size() == 0 || q_b.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            chk("a_state", 32'(st_a), ea.st);
            chk("a_dwell", 32'(dw_a), ea.dw);
            chk("a_adv",   32'(adv_a), 32'(ea.adv));
            chk("a_ret",   32'(ret_a), 32'(ea.ret));
            chk("a_at",    32'(at_a), 32'(1) << ea.st);
            chk("a_done",  32'(done_a), 32'(ea.st == 3));
            chk("b_state", 32'(st_b), eb.st);
            chk("b_dwell", 32'(dw_b), eb.dw);
            chk("b_adv",   32'(adv_b), 32'(eb.adv));
            chk("b_ret",   32'(ret_b), 32'(eb.ret));
            chk("b_at",    32'(at_b), 32'(1) << eb.st);
            chk("b_done",  32'(done_b), 32'(eb.st == 5));
        end
    endtask

    // Drop reset between edges, check the outputs clear before any edge, release mid-cycle.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_a_state", 32'(st_a), 0);
        chk("rst_a_dwell", 32'(dw_a), 0);
        chk("rst_a_done",  32'(done_a), 0);
        chk("rst_a_at",    32'(at_a), 1);
        chk("rst_a_pulse", 32'({adv_a, ret_a}), 0);
        chk("rst_b_state", 32'(st_b), 0);
        chk("rst_b_dwell", 32'(dw_b), 0);
        chk("rst_b_at",    32'(at_b), 1);
        cur_a = '{st: 0, dw: 0, adv: 1'b0, ret: 1'b0};
        cur_b = '{st: 0, dw: 0, adv: 1'b0, ret: 1'b0};
        q_a.delete();
        q_b.delete();
        @(posedge clock);
        #3;
        reset_n = 1'b1;
    endtask

    initial begin
        int   climb_a[4] = '{1, 2, 3, 3};
        int   adv_exp[4] = '{1, 1, 1, 0};
        int   fall_b[5]  = '{3, 2, 1, 0, 0};
        int   ret_exp[5] = '{1, 1, 1, 1, 0};
        logic [3:0] dw_saved;

        reset_n = 1'b0;
        en      = 1'b0;
        i       = 1'b0;
        #1;
        do_reset();

        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1);
            chk("climb_state", 32'(st_a), climb_a[k]);
            chk("climb_adv",   32'(adv_a), adv_exp[k]);
            chk("climb_done",  32'(done_a), 32'(k >= 2));
        end
        chk("b_top_of_climb", 32'(st_b), 4);

        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0);
            chk("back_state", 32'(st_b), fall_b[k]);
            chk("back_ret",   32'(ret_b), ret_exp[k]);
        end
        step(1'b1, 1'b0);
        chk("b_no_auto0", 32'(st_b), 0);

        do_reset();
        step(1'b1, 1'b1);
        chk("reach1", 32'(st_a), 1);
        step(1'b1, 1'b0);
        chk("s1_to_zero", 32'(st_a), 0);
        chk("s1_ret",     32'(ret_a), 1);
        step(1'b1, 1'b0);
        chk("auto0_state", 32'(st_a), 1);
        chk("auto0_adv",   32'(adv_a), 1);
        chk("auto0_ret",   32'(ret_a), 0);

        step(1'b1, 1'b1);
        chk("reach2", 32'(st_a), 2);
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 1'b0);
            chk("hold2_at",    32'(at_a), 32'h4);
            chk("hold2_dwell", 32'(dw_a), (k < 15) ? k : 15);
        end
        step(1'b1, 1'b1);
        chk("leave2_state", 32'(st_a), 3);
        chk("leave2_dwell", 32'(dw_a), 0);

        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        dw_saved = dw_a;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'(k % 2));
            chk("frz_state", 32'(st_a), 2);
            chk("frz_dwell", 32'(dw_a), 32'(dw_saved));
            chk("frz_pulse", 32'({adv_a, ret_a}), 0);
        end
        step(1'b1, 1'b1);
        chk("unfreeze", 32'(st_a), 3);

        #2;
        do_reset();
        step(1'b1, 1'b1);
        chk("post_rst_a", 32'(st_a), 1);
        chk("post_rst_b", 32'(st_b), 1);

        for (int k = 0; k < 80; k++) begin
            if (k == 40) do_reset();
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
